// File: rtl/temp_uart_reporter_pkg.sv
// Shared types and constants for the temperature-to-UART reporter.
package adt_uart_pkg;

  // Top-level message sequencing states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] ZERO  = 8'h30;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;

  localparam int MSG_LEN = 6;

  // Digits 0-9 become '0'..'9'; any non-BCD nibble is flagged as '?'
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
    logic [7:0] result;
    if (digit > 4'd9) begin
      result = QMARK;
    end else begin
      result = ZERO + {4'd0, digit};
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, eight data bits LSB first, one stop bit.
module uart_tx_byte
  import adt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  // tx_done is raised one cycle early so it is visible during the last stop-bit cycle,
  // letting the sequencer queue the next byte with only a single gap cycle.
  localparam logic [BW-1:0] DONE_AT   = BW'(CLKS_PER_BIT - 2);

  logic [BW-1:0] baud_r;
  logic [3:0]    bit_r;
  logic [9:0]    shift_r;
  logic          txd_r;
  logic          busy_r;
  logic          done_r;

  // Frame shifter with baud and bit counters; line idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_r  <= '0;
      bit_r   <= 4'd0;
      shift_r <= 10'h3FF;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!busy_r) begin
        baud_r <= '0;
        bit_r  <= 4'd0;
        if (tx_start) begin
          shift_r <= {1'b1, tx_data, 1'b0};
          txd_r   <= 1'b0;
          busy_r  <= 1'b1;
        end else begin
          txd_r <= 1'b1;
        end
      end else begin
        if ((bit_r == 4'd9) && (baud_r == DONE_AT)) begin
          done_r <= 1'b1;
        end
        if (baud_r == BAUD_LAST) begin
          baud_r <= '0;
          if (bit_r == 4'd9) begin
            busy_r <= 1'b0;
            txd_r  <= 1'b1;
          end else begin
            bit_r   <= bit_r + 4'd1;
            shift_r <= {1'b1, shift_r[9:1]};
            txd_r   <= shift_r[1];
          end
        end else begin
          baud_r <= baud_r + BW'(1);
        end
      end
    end
  end

  assign txd     = txd_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

endmodule

// File: rtl/temp_uart_reporter.sv
// Serialises each BCD temperature sample as "<sign><d><d><d>\r\n" over UART,
// with a one-deep newest-wins pending slot for samples arriving mid-message.
module temp_uart_reporter
  import adt_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        temp_valid,
  input  logic        temp_sign,
  input  logic [11:0] bcd_temp,
  output logic        uart_txd,
  output logic        busy,
  output logic        msg_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("temp_uart_reporter: CLKS_PER_BIT must be at least 4");
    end
  endgenerate

  state_t      state_r;
  logic        msg_sign_r;
  logic [11:0] msg_bcd_r;
  logic        pend_r;
  logic        pend_sign_r;
  logic [11:0] pend_bcd_r;
  logic [2:0]  char_idx_r;
  logic        tx_start_r;
  logic [7:0]  tx_data_r;
  logic        busy_r;
  logic        msg_done_r;

  logic        tx_busy_s;
  logic        tx_done_s;

  // Character idx of the message for the given sample
  function automatic logic [7:0] char_at(input logic [2:0] idx, input logic sign,
                                         input logic [11:0] bcd);
    logic [7:0] c;
    case (idx)
      3'd0:    c = sign ? MINUS : PLUS;
      3'd1:    c = bcd_to_ascii(bcd[11:8]);
      3'd2:    c = bcd_to_ascii(bcd[7:4]);
      3'd3:    c = bcd_to_ascii(bcd[3:0]);
      3'd4:    c = CR;
      3'd5:    c = LF;
      default: c = LF;
    endcase
    return c;
  endfunction

  // Message sequencer, pending-sample capture and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      msg_sign_r  <= 1'b0;
      msg_bcd_r   <= 12'h000;
      pend_r      <= 1'b0;
      pend_sign_r <= 1'b0;
      pend_bcd_r  <= 12'h000;
      char_idx_r  <= 3'd0;
      tx_start_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      busy_r      <= 1'b0;
      msg_done_r  <= 1'b0;
    end else begin
      msg_done_r <= 1'b0;
      tx_start_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (temp_valid) begin
            msg_sign_r <= temp_sign;
            msg_bcd_r  <= bcd_temp;
            busy_r     <= 1'b1;
            state_r    <= LOAD;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (!tx_busy_s) begin
            char_idx_r <= 3'd0;
            tx_data_r  <= char_at(3'd0, msg_sign_r, msg_bcd_r);
            tx_start_r <= 1'b1;
            state_r    <= SEND;
          end else begin
            state_r <= LOAD;
          end
        end
        SEND: begin
          if (tx_done_s) begin
            state_r <= NEXT;
            if (char_idx_r != 3'd5) begin
              tx_data_r  <= char_at(char_idx_r + 3'd1, msg_sign_r, msg_bcd_r);
              tx_start_r <= 1'b1;
            end
          end else begin
            state_r <= SEND;
          end
        end
        NEXT: begin
          if (char_idx_r == 3'd5) begin
            msg_done_r <= 1'b1;
            state_r    <= DONE;
          end else begin
            char_idx_r <= char_idx_r + 3'd1;
            state_r    <= SEND;
          end
        end
        DONE: begin
          if (temp_valid) begin
            msg_sign_r <= temp_sign;
            msg_bcd_r  <= bcd_temp;
            pend_r     <= 1'b0;
            state_r    <= LOAD;
          end else if (pend_r) begin
            msg_sign_r <= pend_sign_r;
            msg_bcd_r  <= pend_bcd_r;
            pend_r     <= 1'b0;
            state_r    <= LOAD;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
      if (temp_valid && (state_r != IDLE) && (state_r != DONE)) begin
        pend_r      <= 1'b1;
        pend_sign_r <= temp_sign;
        pend_bcd_r  <= bcd_temp;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_start(tx_start_r),
    .tx_data (tx_data_r),
    .txd     (uart_txd),
    .tx_busy (tx_busy_s),
    .tx_done (tx_done_s)
  );

  assign busy     = busy_r;
  assign msg_done = msg_done_r;

endmodule
